// File: rtl/rf_addr_port_arbiter_pkg.sv
// rtl/rf_addr_port_arbiter_pkg.sv - shared types and constants for the address-port arbiter
package rf_addr_port_arbiter_pkg;

    localparam int ADDR_W_DEF = 3;
    localparam int HOLD_W     = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_OWN0 = 2'b01,
        ST_OWN1 = 2'b10
    } state_t;

endpackage

// File: rtl/rf_addr_port_arbiter_hold_counter.sv
// rtl/rf_addr_port_arbiter_hold_counter.sv - saturating clearable hold counter with expiry flag
module rr_hold_counter
    import rf_addr_port_arbiter_pkg::*;
#(
    parameter int MAX_HOLD = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic inc_i,
    output logic expired_o
);

    localparam logic [HOLD_W-1:0] LIMIT = HOLD_W'(MAX_HOLD - 1);

    logic [HOLD_W-1:0] cnt_q, cnt_d;

    // Clear has priority; increments stop at the limit so an uncontested owner never wraps
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != LIMIT)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == LIMIT);

endmodule

// File: rtl/rf_addr_port_arbiter_mux.sv
// rtl/rf_addr_port_arbiter_mux.sv - 2:1 register-address mux (0 = D0, 1 = D1)
module rf_addr_mux2 #(
    parameter int W = 3
) (
    input  logic [W-1:0] d0_i,
    input  logic [W-1:0] d1_i,
    input  logic         sel_i,
    output logic [W-1:0] y_o
);

    assign y_o = sel_i ? d1_i : d0_i;

endmodule

// File: rtl/rf_addr_port_arbiter.sv
// rtl/rf_addr_port_arbiter.sv - round-robin arbiter for the shared register-file write-address port
module rf_addr_port_arbiter
    import rf_addr_port_arbiter_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int MAX_HOLD = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              sel,
    output logic [ADDR_W-1:0] addr_out,
    output logic              addr_valid,
    output logic              busy
);

    state_t            state_q, state_d;
    logic              last_winner_q, last_winner_d;
    logic              sel_q, sel_d;
    logic [ADDR_W-1:0] addr_q;
    logic              valid_q;
    logic [ADDR_W-1:0] addr_mux;
    logic              expired;
    logic              enter_own;
    logic              stay_own;

    // Next-state: an owner yields at once when it drops, or after its hold expires while contested
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (req0 && req1) begin
                    state_d = last_winner_q ? ST_OWN0 : ST_OWN1;
                end else if (req0) begin
                    state_d = ST_OWN0;
                end else if (req1) begin
                    state_d = ST_OWN1;
                end
            end
            ST_OWN0: begin
                if (!req0) begin
                    state_d = req1 ? ST_OWN1 : ST_IDLE;
                end else if (req1 && expired) begin
                    state_d = ST_OWN1;
                end
            end
            ST_OWN1: begin
                if (!req1) begin
                    state_d = req0 ? ST_OWN0 : ST_IDLE;
                end else if (req0 && expired) begin
                    state_d = ST_OWN0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Derived next values: select and last winner follow the next owner, hold in IDLE
    always_comb begin
        enter_own     = (state_d != ST_IDLE) && (state_d != state_q);
        stay_own      = (state_d != ST_IDLE) && (state_d == state_q);
        sel_d         = sel_q;
        last_winner_d = last_winner_q;
        if (state_d == ST_OWN0) begin
            sel_d         = 1'b0;
            last_winner_d = 1'b0;
        end else if (state_d == ST_OWN1) begin
            sel_d         = 1'b1;
            last_winner_d = 1'b1;
        end
    end

    rr_hold_counter #(
        .MAX_HOLD (MAX_HOLD)
    ) u_hold (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_i     (enter_own),
        .inc_i     (stay_own),
        .expired_o (expired)
    );

    // Steered by next-state select so the register captures the incoming owner's address
    rf_addr_mux2 #(
        .W (ADDR_W)
    ) u_mux (
        .d0_i  (addr0),
        .d1_i  (addr1),
        .sel_i (sel_d),
        .y_o   (addr_mux)
    );

    // State and output registers; reset clears any grant immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            last_winner_q <= 1'b1;
            sel_q         <= 1'b0;
            addr_q        <= '0;
            valid_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_winner_q <= last_winner_d;
            sel_q         <= sel_d;
            valid_q       <= (state_d != ST_IDLE);
            if (state_d != ST_IDLE) begin
                addr_q <= addr_mux;
            end
        end
    end

    assign gnt0       = (state_q == ST_OWN0);
    assign gnt1       = (state_q == ST_OWN1);
    assign busy       = (state_q != ST_IDLE);
    assign sel        = sel_q;
    assign addr_out   = addr_q;
    assign addr_valid = valid_q;

endmodule
